// File: rtl/bram_window_stream_pkg.sv
// bram_window_stream_pkg: shared state type, sizing helpers and default frame geometry.
package bram_window_stream_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, READY, PROCESS} state_e;
  function automatic int clogb2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction
  function automatic int bank_depth(input int w, input int h, input int k);
    return ((h + k - 1) / k) * w;
  endfunction
  localparam int DEF_RAM_WIDTH    = 8;
  localparam int DEF_IMAGE_WIDTH  = 10;
  localparam int DEF_IMAGE_HEIGHT = 10;
  localparam int DEF_KERNEL_SIZE  = 3;
  localparam int FRAME_PIXELS     = DEF_IMAGE_WIDTH * DEF_IMAGE_HEIGHT;
  localparam int BANK_DEPTH       = bank_depth(DEF_IMAGE_WIDTH, DEF_IMAGE_HEIGHT, DEF_KERNEL_SIZE);
  localparam int ADDR_WIDTH       = clogb2(BANK_DEPTH);
endpackage

// File: rtl/bram_window_stream_if.sv
// bram_window_stream_if: pixel input, control pulses and column-window output of the frame streamer.
interface bram_window_stream_if #(
  parameter int RAM_WIDTH   = 8,
  parameter int KERNEL_SIZE = 3
);
  logic i_start_loading, i_valid, o_ready, o_frame_ready, i_start_process;
  logic o_valid, i_ready, o_eol, o_last;
  logic [RAM_WIDTH-1:0] i_data;
  logic [KERNEL_SIZE*RAM_WIDTH-1:0] o_data;
  modport slave (
    input  i_start_loading, i_valid, i_data, i_start_process, i_ready,
    output o_ready, o_frame_ready, o_valid, o_data, o_eol, o_last
  );
  modport master (
    output i_start_loading, i_valid, i_data, i_start_process, i_ready,
    input  o_ready, o_frame_ready, o_valid, o_data, o_eol, o_last
  );
endinterface

// File: rtl/bram_bank.sv
// bram_bank: simple dual-port RAM with one write port and one registered read port.
module bram_bank #(
  parameter int DW    = 8,
  parameter int DEPTH = 40,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/bram_window_stream.sv
// bram_window_stream: stores a frame in KERNEL_SIZE row-interleaved banks and streams column windows.
// Define BRAM_WINDOW_PAD_EN for vertical zero padding (one band per image row, out-of-frame lanes read 0).
module bram_window_stream
  import bram_window_stream_pkg::*;
#(
  parameter int RAM_WIDTH    = DEF_RAM_WIDTH,
  parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
  parameter int KERNEL_SIZE  = DEF_KERNEL_SIZE
) (
  input logic clk,
  input logic reset,
  bram_window_stream_if.slave s
);
`ifdef BRAM_WINDOW_PAD_EN
  localparam int PAD    = (KERNEL_SIZE - 1) / 2;
  localparam int NBANDS = IMAGE_HEIGHT;
`else
  localparam int PAD    = 0;
  localparam int NBANDS = IMAGE_HEIGHT - KERNEL_SIZE + 1;
`endif
  localparam int DEPTH = bank_depth(IMAGE_WIDTH, IMAGE_HEIGHT, KERNEL_SIZE);
  localparam int AW    = clogb2(DEPTH);
  localparam int CW    = clogb2(IMAGE_WIDTH);
  localparam int RW    = clogb2(IMAGE_HEIGHT);
  localparam int BW    = clogb2(KERNEL_SIZE);
  localparam int GW    = clogb2(IMAGE_HEIGHT / KERNEL_SIZE + 3);
  localparam int NW    = clogb2(NBANDS);
  localparam int DW    = KERNEL_SIZE * RAM_WIDTH;
  // Band top is tracked as t+KERNEL_SIZE (mod part tm, group part tg) so padded bands stay non-negative.
  localparam int TM0   = (KERNEL_SIZE - PAD) % KERNEL_SIZE;
  localparam int TG0   = (KERNEL_SIZE - PAD) / KERNEL_SIZE;
  state_e st_q, st_d;
  logic [CW-1:0] wc_q, wc_d, rc_q, rc_d;
  logic [RW-1:0] wr_q, wr_d;
  logic [BW-1:0] wb_q, wb_d, tm_q, tm_d, tm_p_q;
  logic [GW-1:0] wg_q, wg_d, tg_q, tg_d;
  logic [NW-1:0] band_q, band_d;
  logic done_q, done_d, inf_q, eol_p_q, last_p_q;
  logic [1:0] cnt_q;
  logic [DW-1:0] d0_q, d1_q, din;
  logic e0_q, e1_q, l0_q, l1_q;
  logic accept, row_wrap, wr_end, rd_eol, rd_last, pop, space, issue, shift, load0, load1;
  logic [AW-1:0] waddr;
  logic [AW-1:0] raddr [KERNEL_SIZE];
  logic [RAM_WIDTH-1:0] rdata [KERNEL_SIZE];
`ifdef BRAM_WINDOW_PAD_EN
  logic [KERNEL_SIZE-1:0] rd_ok, ok_p_q;
`endif
  assign accept   = st_q == LOAD && s.i_valid;
  assign row_wrap = wc_q == CW'(IMAGE_WIDTH - 1);
  assign wr_end   = row_wrap && wr_q == RW'(IMAGE_HEIGHT - 1);
  assign rd_eol   = rc_q == CW'(IMAGE_WIDTH - 1);
  assign rd_last  = rd_eol && band_q == NW'(NBANDS - 1);
  assign pop      = cnt_q != 2'd0 && s.i_ready;
  // Counting the read in flight and this cycle's pop lets two entries sustain one vector per cycle.
  assign space    = int'(cnt_q) + int'(inf_q) - int'(pop) < 2;
  assign issue    = space && ((st_q == READY && s.i_start_process) || (st_q == PROCESS && !done_q));
  assign waddr    = AW'(int'(wg_q) * IMAGE_WIDTH + int'(wc_q));
  always_ff @(posedge clk or negedge reset)
    if (!reset) st_q <= IDLE;
    else st_q <= st_d;
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE:    st_d = s.i_start_loading ? LOAD : IDLE;
      LOAD:    st_d = (accept && wr_end) ? READY : LOAD;
      READY:   st_d = s.i_start_process ? PROCESS : (s.i_start_loading ? LOAD : READY);
      PROCESS: st_d = (pop && l0_q) ? READY : PROCESS;
      default: st_d = IDLE;
    endcase
  end
  always_comb begin
    s.o_ready       = st_q == LOAD;
    s.o_frame_ready = st_q == READY || st_q == PROCESS;
  end
  always_comb begin
    wc_d = wc_q; wr_d = wr_q; wb_d = wb_q; wg_d = wg_q;
    rc_d = rc_q; tm_d = tm_q; tg_d = tg_q; band_d = band_q; done_d = done_q;
    if (accept) begin
      wc_d = row_wrap ? '0 : wc_q + 1'b1;
      if (row_wrap) begin
        wr_d = wr_end ? '0 : wr_q + 1'b1;
        wb_d = (wr_end || wb_q == BW'(KERNEL_SIZE - 1)) ? '0 : wb_q + 1'b1;
        wg_d = wr_end ? '0 : (wb_q == BW'(KERNEL_SIZE - 1) ? wg_q + 1'b1 : wg_q);
      end
    end
    if (issue) begin
      rc_d   = rd_eol ? '0 : rc_q + 1'b1;
      done_d = rd_last;
      if (rd_eol) begin
        band_d = rd_last ? '0 : band_q + 1'b1;
        tm_d   = rd_last ? BW'(TM0) : (tm_q == BW'(KERNEL_SIZE - 1) ? '0 : tm_q + 1'b1);
        tg_d   = rd_last ? GW'(TG0) : (tm_q == BW'(KERNEL_SIZE - 1) ? tg_q + 1'b1 : tg_q);
      end
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wc_q <= '0; wr_q <= '0; wb_q <= '0; wg_q <= '0;
      rc_q <= '0; tm_q <= BW'(TM0); tg_q <= GW'(TG0); band_q <= '0; done_q <= 1'b0;
      inf_q <= 1'b0; tm_p_q <= '0; eol_p_q <= 1'b0; last_p_q <= 1'b0;
    end else begin
      wc_q <= wc_d; wr_q <= wr_d; wb_q <= wb_d; wg_q <= wg_d;
      rc_q <= rc_d; tm_q <= tm_d; tg_q <= tg_d; band_q <= band_d; done_q <= done_d;
      inf_q <= issue;
      if (issue) begin
        tm_p_q   <= tm_q;
        eol_p_q  <= rd_eol;
        last_p_q <= rd_last;
      end
    end
  for (genvar b = 0; b < KERNEL_SIZE; b++) begin : g_bank
    logic [GW-1:0] g;
    assign g = (int'(tm_q) <= b) ? tg_q : tg_q + 1'b1;
`ifdef BRAM_WINDOW_PAD_EN
    assign rd_ok[b] = int'(g) * KERNEL_SIZE + b >= KERNEL_SIZE &&
                      int'(g) * KERNEL_SIZE + b < IMAGE_HEIGHT + KERNEL_SIZE;
    assign raddr[b] = rd_ok[b] ? AW'((int'(g) - 1) * IMAGE_WIDTH + int'(rc_q)) : '0;
`else
    assign raddr[b] = AW'((int'(g) - 1) * IMAGE_WIDTH + int'(rc_q));
`endif
    bram_bank #(.DW(RAM_WIDTH), .DEPTH(DEPTH), .AW(AW)) u_bank (
      .clk     (clk),
      .we_i    (accept && wb_q == BW'(b)),
      .waddr_i (waddr),
      .wdata_i (s.i_data),
      .re_i    (issue),
      .raddr_i (raddr[b]),
      .rdata_o (rdata[b])
    );
  end
  for (genvar j = 0; j < KERNEL_SIZE; j++) begin : g_lane
    logic [BW-1:0] sel;
    assign sel = BW'((int'(tm_p_q) + j) % KERNEL_SIZE);
`ifdef BRAM_WINDOW_PAD_EN
    assign din[j*RAM_WIDTH +: RAM_WIDTH] = ok_p_q[sel] ? rdata[sel] : '0;
`else
    assign din[j*RAM_WIDTH +: RAM_WIDTH] = rdata[sel];
`endif
  end
`ifdef BRAM_WINDOW_PAD_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) ok_p_q <= '0;
    else if (issue) ok_p_q <= rd_ok;
`endif
  assign shift = pop && cnt_q == 2'd2;
  assign load0 = inf_q && (cnt_q == 2'd0 || (cnt_q == 2'd1 && pop));
  assign load1 = inf_q && ((cnt_q == 2'd1 && !pop) || (cnt_q == 2'd2 && pop));
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt_q <= '0; d0_q <= '0; d1_q <= '0;
      e0_q <= 1'b0; e1_q <= 1'b0; l0_q <= 1'b0; l1_q <= 1'b0;
    end else begin
      cnt_q <= cnt_q + {1'b0, inf_q} - {1'b0, pop};
      if (shift) begin
        d0_q <= d1_q; e0_q <= e1_q; l0_q <= l1_q;
      end else if (load0) begin
        d0_q <= din; e0_q <= eol_p_q; l0_q <= last_p_q;
      end
      if (load1) begin
        d1_q <= din; e1_q <= eol_p_q; l1_q <= last_p_q;
      end
    end
  assign s.o_valid = cnt_q != 2'd0;
  assign s.o_data  = d0_q;
  assign s.o_eol   = e0_q;
  assign s.o_last  = l0_q;
endmodule

// File: tb/tb_bram_window_stream.sv
// tb_bram_window_stream: directed checks of load, streaming, backpressure and reset for W=H=10, K=3.
module tb_bram_window_stream;
  localparam int W = 10;
  localparam int H = 10;
`ifdef BRAM_WINDOW_PAD_EN
  localparam int P = 1;
  localparam int NV = 100;
  localparam logic [23:0] FIRST = 24'h0B0100;
  localparam logic [23:0] V11   = 24'h150B01;
  localparam logic [23:0] LASTV = 24'h00645A;
`else
  localparam int P = 0;
  localparam int NV = 80;
  localparam logic [23:0] FIRST = 24'h150B01;
  localparam logic [23:0] V11   = 24'h1F150B;
  localparam logic [23:0] LASTV = 24'h645A50;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  logic [25:0] cap[$];
  logic [25:0] ref1[$];
  int first_v, first_h, last_h;
  bram_window_stream_if #(.RAM_WIDTH(8), .KERNEL_SIZE(3)) bus ();
  bram_window_stream dut (.clk(clk), .reset(rst_n), .s(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [25:0] model(input int i);
    int t, c, r;
    logic [23:0] d;
    t = i / W - P;
    c = i % W;
    d = '0;
    for (int j = 0; j < 3; j++) begin
      r = t + j;
      if (r >= 0 && r < H) d[j*8 +: 8] = 8'(10 * r + c + 1);
    end
    return {i == NV - 1, c == W - 1, d};
  endfunction
  task automatic run_stream(input bit bp, input bit inj);
    bit held, got_last;
    logic [25:0] hd;
    cap.delete();
    first_v = -1; first_h = -1; last_h = -1;
    held = 0; got_last = 0; hd = '0;
    bus.i_ready = 1'b1;
    bus.i_start_process = 1'b1;
    @(negedge clk);
    bus.i_start_process = 1'b0;
    for (int n = 0; n < 600 && !got_last; n++) begin
      if (held) chk("stall_hold", {bus.o_valid, bus.o_last, bus.o_eol, bus.o_data}, {1'b1, hd});
      if (inj && n > 20 && n < 24) chk("load_ignored", bus.o_ready, 1'b0);
      bus.i_start_loading = inj && n == 20;
      bus.i_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (bus.o_valid && first_v < 0) first_v = n;
      if (bus.o_valid && bus.i_ready) begin
        cap.push_back({bus.o_last, bus.o_eol, bus.o_data});
        if (first_h < 0) first_h = n;
        last_h = n;
        got_last = bus.o_last;
      end
      held = bus.o_valid && !bus.i_ready;
      hd = {bus.o_last, bus.o_eol, bus.o_data};
      @(negedge clk);
    end
    bus.i_ready = 1'b1;
    bus.i_start_loading = 1'b0;
  endtask
  initial begin
    int k, rc, last_hs, first_fr, seen;
    bus.i_start_loading = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_data = '0;
    bus.i_start_process = 1'b0;
    bus.i_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", bus.o_ready, 1'b0);
    chk("rst_frame_ready", bus.o_frame_ready, 1'b0);
    chk("rst_valid", bus.o_valid, 1'b0);
    chk("rst_eol", bus.o_eol, 1'b0);
    chk("rst_last", bus.o_last, 1'b0);
    chk("rst_data", bus.o_data, 24'h0);
    rst_n = 1'b1;
    @(negedge clk);
    bus.i_start_process = 1'b1;
    @(negedge clk);
    bus.i_start_process = 1'b0;
    chk("idle_ignores_process", bus.o_valid, 1'b0);
    bus.i_start_loading = 1'b1;
    @(negedge clk);
    bus.i_start_loading = 1'b0;
    k = 0; rc = 0; last_hs = -1; first_fr = -1;
    for (int n = 0; n < 120; n++) begin
      if (bus.o_frame_ready && first_fr < 0) first_fr = n;
      bus.i_valid = k < 100;
      bus.i_data = 8'(k + 1);
      if (bus.o_ready) begin
        rc++;
        if (bus.i_valid) begin
          k++;
          last_hs = n;
        end
      end
      @(negedge clk);
    end
    bus.i_valid = 1'b0;
    chk("load_ready_cycles", rc, 100);
    chk("load_last_handshake", last_hs, 99);
    chk("frame_ready_rise", first_fr, 100);
    chk("frame_ready_hold", bus.o_frame_ready, 1'b1);
    run_stream(1'b0, 1'b0);
    chk("s1_first_valid_lat", first_v, 1);
    chk("s1_count", cap.size(), NV);
    chk("s1_back_to_back", last_h - first_h, NV - 1);
    chk("s1_first", cap[0][23:0], FIRST);
    chk("s1_vec11", cap[10][23:0], V11);
    chk("s1_last_data", cap[NV-1][23:0], LASTV);
    chk("s1_last_flag", cap[NV-1][25], 1'b1);
    for (int i = 0; i < cap.size(); i++) chk($sformatf("s1_vec%0d", i), cap[i], model(i));
    chk("s1_done_valid", bus.o_valid, 1'b0);
    chk("s1_done_frame_ready", bus.o_frame_ready, 1'b1);
    ref1 = cap;
    run_stream(1'b1, 1'b1);
    chk("s2_first_valid_lat", first_v, 1);
    chk("s2_count", cap.size(), NV);
    for (int i = 0; i < cap.size() && i < ref1.size(); i++) chk($sformatf("s2_vec%0d", i), cap[i], ref1[i]);
    chk("s2_done_frame_ready", bus.o_frame_ready, 1'b1);
    bus.i_start_process = 1'b1;
    @(negedge clk);
    bus.i_start_process = 1'b0;
    repeat (12) @(negedge clk);
    chk("mid_valid", bus.o_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", bus.o_valid, 1'b0);
    chk("arst_data", bus.o_data, 24'h0);
    chk("arst_flags", {bus.o_eol, bus.o_last}, 2'b00);
    chk("arst_frame_ready", bus.o_frame_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.i_start_process = 1'b1;
    @(negedge clk);
    bus.i_start_process = 1'b0;
    seen = 0;
    repeat (6) begin
      if (bus.o_valid) seen++;
      @(negedge clk);
    end
    chk("post_rst_no_stream", seen, 0);
    chk("post_rst_frame_ready", bus.o_frame_ready, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bram_window_stream.md
# bram_window_stream

Frame buffer and column-window streamer for the convolution datapath. Accepts one image frame pixel-by-pixel over a valid/ready handshake and stores it in KERNEL_SIZE row-interleaved BRAM banks. On command, it streams one KERNEL_SIZE-tall pixel column per cycle to the convolver. It generalises the fixed 3-row BRAM controller with a parametric kernel height, handshakes on both sides, frame markers and optional vertical zero padding.

## Interface
- RAM_WIDTH, 8, pixel width in bits
- IMAGE_WIDTH, 10, pixels per row (≥ 2)
- IMAGE_HEIGHT, 10, rows per frame (≥ KERNEL_SIZE)
- KERNEL_SIZE, 3, rows per output vector (odd, ≥ 1)
- clk  input  1  clock; all logic on the rising edge
- reset  input  1  asynchronous, active-low reset
- i_start_loading  input  1  pulse: begin accepting a new frame
- i_valid  input  1  input pixel valid
- i_data  input  RAM_WIDTH  input pixel, raster order
- o_ready  output  1  block accepts a pixel this cycle
- o_frame_ready  output  1  complete frame stored
- i_start_process  input  1  pulse: stream the stored frame
- o_valid  output  1  output vector valid
- i_ready  input  1  convolver accepts the vector
- o_data  output  KERNEL_SIZE*RAM_WIDTH  lane j = bits [j*RAM_WIDTH +: RAM_WIDTH], row top+j
- o_eol  output  1  qualifies o_valid: last column of current band
- o_last  output  1  qualifies o_valid: last vector of frame

## Operation
- States:
  - IDLE: → LOAD on i_start_loading.
  - LOAD: → READY after IMAGE_WIDTH*IMAGE_HEIGHT accepted pixels.
  - READY: → PROCESS on i_start_process; → LOAD on i_start_loading.
  - PROCESS: → READY on the handshake of the o_last vector.
- Start pulses received in any other state are ignored.
- o_ready = 1 only in LOAD. A pixel is accepted when i_valid & o_ready. Pixel (r,c) is written to bank r mod KERNEL_SIZE at address (r / KERNEL_SIZE)*IMAGE_WIDTH + c.
- o_frame_ready = 1 in READY and PROCESS. The frame is retained, so repeated i_start_process re-streams it unchanged.
- PROCESS band order: top row t ascends; for each band, columns c = 0..IMAGE_WIDTH-1. Every bank is read in the same cycle. A rotation mux maps bank (t+j) mod KERNEL_SIZE to lane j.
- o_eol is asserted when c = IMAGE_WIDTH-1. o_last is asserted on the final vector.
- The producer holds o_data, o_eol and o_last stable while o_valid & !i_ready.
- Address counters are clog2-sized and wrap to 0 at row and band ends. There are no out-of-range BRAM accesses.

## Timing
- Reset: state IDLE. o_ready, o_frame_ready, o_valid, o_eol and o_last are all 0; o_data is 0; all counters are 0. BRAM contents are undefined.
- BRAM read latency is 1 cycle. A 2-entry skid buffer after the read stage gives full throughput.
- The first o_valid rises 2 cycles after the cycle i_start_process is sampled.
- With i_ready held at 1, one vector is delivered per cycle with no bubbles, including across band boundaries.
- When i_ready deasserts, no vector is lost or duplicated. Reads stall once the skid buffer is full.
- The last pixel handshake sets o_frame_ready on the next cycle.
- Reset asserted mid-LOAD or mid-PROCESS returns to IDLE immediately. The frame is invalidated and o_valid drops asynchronously.

## Configuration
- BRAM_WINDOW_PAD_EN defined:
  - Bands run t = -(KERNEL_SIZE-1)/2 .. IMAGE_HEIGHT-1-(KERNEL_SIZE-1)/2.
  - Lanes whose row lies outside 0..IMAGE_HEIGHT-1 output 0.
  - IMAGE_HEIGHT*IMAGE_WIDTH vectors per frame.
- BRAM_WINDOW_PAD_EN undefined:
  - Bands run t = 0 .. IMAGE_HEIGHT-KERNEL_SIZE.
  - (IMAGE_HEIGHT-KERNEL_SIZE+1)*IMAGE_WIDTH vectors per frame.
  - Padding logic is absent.

## Structure
- Shared package holds:
  - state enum (IDLE, LOAD, READY, PROCESS);
  - clogb2 function;
  - derived localparams: FRAME_PIXELS, BANK_DEPTH = ceil(IMAGE_HEIGHT/KERNEL_SIZE)*IMAGE_WIDTH, address widths.
- Sub-module bram_bank: simple dual-port RAM with 1 write port and 1 registered read port, instantiated KERNEL_SIZE times via generate.

## Test plan
All scenarios use W=10, H=10, K=3 and pixel (r,c) = 10r+c+1.
- Load with i_valid continuous → o_ready high for exactly 100 cycles; o_frame_ready rises the cycle after the 100th handshake.
- Process without pad, i_ready=1:
  - exactly 80 vectors, back-to-back;
  - first vector lanes {1,11,21};
  - vector 11 (t=1, c=0) lanes {11,21,31};
  - last vector {80,90,100} with o_last=1;
  - o_eol on every 10th vector.
- Process with BRAM_WINDOW_PAD_EN: 100 vectors; first {0,1,11}; last {90,100,0}.
- Random i_ready backpressure → output sequence identical to the i_ready=1 run; o_data stable during stalls.
- i_start_loading during PROCESS is ignored. A second i_start_process after completion reproduces an identical stream.
- Reset asserted mid-PROCESS → all outputs 0. i_start_process is then ignored until a new frame is loaded.
